out_port: RTL and testbench
===========================

Name: out_port

Overview:
- Output port for the 8-bit RISC datapath; the outbound counterpart of the input-select mux feeding the bus.
- When the core asserts `oe`, the byte on Bus_D is captured into a small FIFO.
- The FIFO drains to an external device over a valid/ready handshake.
- Full/empty status is returned to the control unit so it can stall OUT instructions.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- PTR_W, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- Bus_D  input  8  data bus from the register file/ALU.
- oe  input  1  output enable; request to push Bus_D this cycle.
- clr_ovf  input  1  clears the sticky overflow flag.
- port_full  output  1  FIFO holds DEPTH entries.
- port_empty  output  1  FIFO holds 0 entries.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; a push was attempted while full.
- data_out  output  8  head-of-FIFO byte to the external device.
- out_valid  output  1  data_out is valid.
- out_ready  input  1  external device accepts data_out this cycle.

Behaviour:
- Interface decided: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst=1 at an edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, overflow=0, port_empty=1, port_full=0, data_out=8'h00.
  - Storage contents are don't-care.
  - Reset overrides oe, out_ready and clr_ovf in the same cycle.
  - Reset mid-transfer discards all queued bytes.
- Push:
  - push = oe & ~port_full.
  - On push: mem[wr_ptr] <= Bus_D; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Pop:
  - pop = out_valid & out_ready.
  - On pop: rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- Count: count <= count + push - pop. Simultaneous push and pop leaves count unchanged.
- Full-FIFO push:
  - A push attempted while port_full=1 is rejected even if a pop occurs in the same cycle. Bus_D is dropped and overflow <= 1.
  - overflow is cleared only by rst or clr_ovf.
  - If clr_ovf and a rejected push occur in the same cycle, set wins and overflow=1.
- Flags are combinational from count:
  - port_full = (count==DEPTH).
  - port_empty = (count==0).
  - out_valid = ~port_empty.
- data_out = mem[rd_ptr] when out_valid=1, else 8'h00. First-word fall-through.
- Latency: a byte pushed at edge N appears on data_out with out_valid=1 after edge N (visible in cycle N+1).
- Empty FIFO:
  - out_ready is ignored; no pop occurs.
  - A push into an empty FIFO with out_ready=1 is not forwarded in the same cycle.
- Hold rule: data_out and out_valid hold stable while out_valid=1 and out_ready=0.
- Ordering: strict FIFO; no reordering or duplication; pointers wrap cleanly across DEPTH.

Optional Feature:
- Macro: OUTPORT_PARITY_EN.
- When defined:
  - Adds output port `parity_out` (1 bit) = even parity (XOR) of data_out while out_valid=1, else 0.
  - Storage widens to 9 bits per entry; parity is computed from Bus_D at push time.
- When undefined: no parity_out port, 8-bit storage; behaviour is otherwise identical.

Test Plan:
- Reset check: assert rst 2 cycles with oe=1, Bus_D=8'hFF -> count=0, port_empty=1, out_valid=0, data_out=8'h00, overflow=0.
- Single transfer: push 8'hA5 with out_ready=0 -> next cycle out_valid=1, data_out=8'hA5, count=1. Hold 3 cycles -> value stable. Pulse out_ready -> port_empty=1.
- Fill and overflow: push 8'h01..8'h04 -> port_full=1, count=4. Push 8'h05 -> rejected, overflow=1. Drain yields 01,02,03,04 in order. clr_ovf -> overflow=0.
- Simultaneous push/pop: count=2, oe=1 and out_ready=1 for 6 cycles with Bus_D incrementing from 8'h10 -> count stays 2. Output order is contiguous across pointer wrap.
- Full plus pop: FIFO full, oe=1 with Bus_D=8'h77 and out_ready=1 in the same cycle -> count=3, 8'h77 absent from the drained stream, overflow=1.
- Reset mid-stream: 3 entries queued, rst pulsed while out_ready=1 -> FIFO empty next cycle. A following push of 8'h3C emerges first.
- (OUTPORT_PARITY_EN) push 8'h07 -> parity_out=1; push 8'h03 -> parity_out=0.

Source files
------------

// File: rtl/out_port.sv
// Output port FIFO: captures Bus_D on oe and drains it first-word-fall-through over valid/ready.
// Optional OUTPORT_PARITY_EN adds a parity_out port and a stored parity bit per entry.
module out_port #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       Bus_D,
    input  logic             oe,
    input  logic             clr_ovf,
    output logic             port_full,
    output logic             port_empty,
    output logic [PTR_W:0]   count,
    output logic             overflow,
    output logic [7:0]       data_out,
    output logic             out_valid,
    input  logic             out_ready
`ifdef OUTPORT_PARITY_EN
    ,
    output logic             parity_out
`endif
);

`ifdef OUTPORT_PARITY_EN
    localparam int W = 9;
`else
    localparam int W = 8;
`endif

    logic [W-1:0]   mem [DEPTH];
    logic [W-1:0]   wr_word;
    logic [W-1:0]   head_word;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push, pop;

    always_comb begin
`ifdef OUTPORT_PARITY_EN
        wr_word = {^Bus_D, Bus_D};
`else
        wr_word = Bus_D;
`endif
        head_word = mem[rd_ptr_q];
    end

    // Flags derive purely from occupancy so they can never disagree with count.
    always_comb begin
        port_full  = (count_q == (PTR_W+1)'(DEPTH));
        port_empty = (count_q == '0);
        out_valid  = ~port_empty;
        count      = count_q;
        overflow   = overflow_q;
        data_out   = out_valid ? head_word[7:0] : 8'h00;
`ifdef OUTPORT_PARITY_EN
        parity_out = out_valid & head_word[8];
`endif
    end

    always_comb begin
        push       = oe & ~port_full;
        pop        = out_valid & out_ready;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        overflow_d = overflow_q;
        // A rejected push takes priority over a simultaneous clear.
        if (oe && port_full) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage has no reset; stale contents are masked by count.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr_q] <= wr_word;
        end
    end

endmodule

// File: tb/tb_out_port.sv
// Scoreboard bench for out_port: stimulus updates a queue-based model, a monitor checks every cycle.
module tb_out_port;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic           clk;
    logic           rst;
    logic [7:0]     Bus_D;
    logic           oe;
    logic           clr_ovf;
    logic           port_full;
    logic           port_empty;
    logic [PTR_W:0] count;
    logic           overflow;
    logic [7:0]     data_out;
    logic           out_valid;
    logic           out_ready;
`ifdef OUTPORT_PARITY_EN
    logic           parity_out;
`endif

    out_port #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .Bus_D      (Bus_D),
        .oe         (oe),
        .clr_ovf    (clr_ovf),
        .port_full  (port_full),
        .port_empty (port_empty),
        .count      (count),
        .overflow   (overflow),
        .data_out   (data_out),
        .out_valid  (out_valid),
`ifdef OUTPORT_PARITY_EN
        .parity_out (parity_out),
`endif
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: sb_q holds queued bytes in order; m_ovf is the sticky flag.
    logic [7:0] sb_q [$];
    bit         m_ovf;
    bit         mon_en;
    int         checks;
    int         errors;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit o, input logic [7:0] d, input bit rdy, input bit clr);
        bit full;
        bit push;
        @(negedge clk);
        rst       = r;
        oe        = o;
        Bus_D     = d;
        out_ready = rdy;
        clr_ovf   = clr;
        full = (sb_q.size() == DEPTH);
        push = o && !full;
        @(posedge clk);
        if (r) begin
            sb_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (push) sb_q.push_back(d);
            if (o && full) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
        $display("cyc rst=%0b oe=%0b d=%02h rdy=%0b clr=%0b -> model_count=%0d ovf=%0b",
                 r, o, d, rdy, clr, sb_q.size(), m_ovf);
    endtask

    // Monitor: status every cycle; on each handshake the head is popped and compared.
    always begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            logic [7:0] exp_head;
            int n;
            n = sb_q.size();
            exp_head = (n > 0) ? sb_q[0] : 8'h00;
            chk("count", int'(count), n);
            chk("port_empty", int'(port_empty), int'(n == 0));
            chk("port_full", int'(port_full), int'(n == DEPTH));
            chk("out_valid", int'(out_valid), int'(n > 0));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("data_out", int'(data_out), int'(exp_head));
`ifdef OUTPORT_PARITY_EN
            chk("parity_out", int'(parity_out), int'(^exp_head));
`endif
            if (!rst && out_valid && out_ready) begin
                if (n == 0) begin
                    chk("pop_underflow", 1, 0);
                end else begin
                    chk("pop_data", int'(data_out), int'(sb_q[0]));
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1; oe = 1'b0; Bus_D = 8'h00; out_ready = 1'b0; clr_ovf = 1'b0;
        checks = 0; errors = 0; m_ovf = 1'b0; mon_en = 1'b0;

        // Reset with oe and Bus_D asserted
        step(1, 1, 8'hFF, 0, 0);
        mon_en = 1'b1;
        step(1, 1, 8'hFF, 0, 0);
        step(0, 0, 8'h00, 0, 0);

        // Single transfer with hold
        step(0, 1, 8'hA5, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 0);

        // Fill, overflow, drain, clear
        for (int i = 1; i <= 4; i++) step(0, 1, 8'(i), 0, 0);
        step(0, 1, 8'h05, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 0);

        // Simultaneous push/pop at count=2, across pointer wrap
        step(0, 1, 8'h0E, 0, 0);
        step(0, 1, 8'h0F, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 8'(8'h10 + i), 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 0);

        // Full plus pop: push rejected, overflow set
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h60 + i), 0, 0);
        step(0, 1, 8'h77, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 0);
        step(0, 1, 8'h88, 0, 1);

        // Reset mid-stream
        step(0, 1, 8'h21, 0, 0);
        step(0, 1, 8'h22, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 1, 0);
        step(0, 1, 8'h3C, 0, 0);
        step(0, 0, 8'h00, 1, 0);

        // Parity patterns (also exercised on the default build as plain data)
        step(0, 1, 8'h07, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 1, 8'h03, 0, 0);
        step(0, 0, 8'h00, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 99) < 55,
                 8'($urandom_range(0, 255)),
                 $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 5);
        end
        for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
